// File: rtl/regfile_operand_fetch_pkg.sv
// Shared types and constants for the register-file operand-fetch stage.
package regfile_operand_fetch_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RDWAIT = 2'd1,
        HOLD   = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_ZERO = 2'd1,
        SEL_FWD  = 2'd2,
        SEL_RF   = 2'd3
    } op_sel_e;

    // A writeback hits an operand only for a matching non-zero register.
    function automatic logic fwd_hit(input logic we, input reg_addr_t wa, input reg_addr_t ra);
        return we && (wa == ra) && (ra != ZERO_REG);
    endfunction

endpackage

// File: rtl/regfile_operand_fetch_if.sv
// Bundle of decode, writeback, register-file and execute signals seen by the fetch stage.
interface regfile_operand_fetch_if
    import regfile_operand_fetch_pkg::*;
#(
    parameter int WIDTH = 32
);

    logic             req_valid;
    logic             req_ready;
    reg_addr_t        req_ra0;
    reg_addr_t        req_ra1;

    logic             wb_we;
    reg_addr_t        wb_wa;
    logic [WIDTH-1:0] wb_wd;

    reg_addr_t        rf_ra0;
    reg_addr_t        rf_ra1;
    logic             rf_we;
    reg_addr_t        rf_wa;
    logic [WIDTH-1:0] rf_wd;
    logic [WIDTH-1:0] rf_rd0;
    logic [WIDTH-1:0] rf_rd1;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] op0;
    logic [WIDTH-1:0] op1;

    modport slave (
        input  req_valid, req_ra0, req_ra1,
        input  wb_we, wb_wa, wb_wd,
        input  rf_rd0, rf_rd1,
        input  out_ready,
        output req_ready,
        output rf_ra0, rf_ra1, rf_we, rf_wa, rf_wd,
        output out_valid, op0, op1
    );

    modport master (
        output req_valid, req_ra0, req_ra1,
        output wb_we, wb_wa, wb_wd,
        output rf_rd0, rf_rd1,
        output out_ready,
        input  req_ready,
        input  rf_ra0, rf_ra1, rf_we, rf_wa, rf_wd,
        input  out_valid, op0, op1
    );

endinterface

// File: rtl/regfile_operand_fetch_operand_select.sv
// Next-value mux for one held operand: zero, writeback forward, file read data or hold.
module regfile_operand_fetch_operand_select
    import regfile_operand_fetch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  fetch_state_e     state,
    input  logic             out_ready,
    input  reg_addr_t        ra,
    input  logic             wb_we,
    input  reg_addr_t        wb_wa,
    input  logic [WIDTH-1:0] wb_wd,
    input  logic [WIDTH-1:0] rf_rd,
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    op_sel_e sel;

    always_comb begin
        sel = SEL_HOLD;
        unique case (state)
            RDWAIT: begin
                if (ra == ZERO_REG)
                    sel = SEL_ZERO;
                else if (fwd_hit(wb_we, wb_wa, ra))
                    sel = SEL_FWD;
                else
                    sel = SEL_RF;
            end
            // A write in the handshake cycle must not touch the departing operand.
            HOLD: begin
                if (!out_ready && fwd_hit(wb_we, wb_wa, ra))
                    sel = SEL_FWD;
            end
            default: sel = SEL_HOLD;
        endcase
    end

    always_comb begin
        nxt = cur;
        unique case (sel)
            SEL_ZERO: nxt = '0;
            SEL_FWD:  nxt = wb_wd;
            SEL_RF:   nxt = rf_rd;
            default:  nxt = cur;
        endcase
    end

endmodule

// File: rtl/regfile_operand_fetch.sv
// Operand-fetch stage: turns the BRAM register file's 1-cycle read into a valid/ready
// operand stream, yielding the port to writes and forwarding writeback into held operands.
module regfile_operand_fetch
    import regfile_operand_fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    regfile_operand_fetch_if.slave bus,
    output logic [CNT_W-1:0]  stall_cnt
);

    fetch_state_e     state;
    reg_addr_t        held_ra0;
    reg_addr_t        held_ra1;
    logic [WIDTH-1:0] op0_q;
    logic [WIDTH-1:0] op1_q;
    logic [WIDTH-1:0] op0_d;
    logic [WIDTH-1:0] op1_d;
    logic             out_valid_q;
    logic             ready;
    logic             accept;

    always_comb begin
        ready  = !bus.wb_we && ((state == IDLE) || ((state == HOLD) && bus.out_ready));
        accept = bus.req_valid && ready;
    end

    assign bus.req_ready = ready;

    // The file reads the new addresses in the accept cycle so data lands during RDWAIT.
    assign bus.rf_ra0 = accept ? bus.req_ra0 : held_ra0;
    assign bus.rf_ra1 = accept ? bus.req_ra1 : held_ra1;

    assign bus.rf_we  = bus.wb_we;
    assign bus.rf_wa  = bus.wb_wa;
    assign bus.rf_wd  = bus.wb_wd;

    assign bus.out_valid = out_valid_q;
    assign bus.op0       = op0_q;
    assign bus.op1       = op1_q;

    regfile_operand_fetch_operand_select #(.WIDTH(WIDTH)) u_sel0 (
        .state     (state),
        .out_ready (bus.out_ready),
        .ra        (held_ra0),
        .wb_we     (bus.wb_we),
        .wb_wa     (bus.wb_wa),
        .wb_wd     (bus.wb_wd),
        .rf_rd     (bus.rf_rd0),
        .cur       (op0_q),
        .nxt       (op0_d)
    );

    regfile_operand_fetch_operand_select #(.WIDTH(WIDTH)) u_sel1 (
        .state     (state),
        .out_ready (bus.out_ready),
        .ra        (held_ra1),
        .wb_we     (bus.wb_we),
        .wb_wa     (bus.wb_wa),
        .wb_wd     (bus.wb_wd),
        .rf_rd     (bus.rf_rd1),
        .cur       (op1_q),
        .nxt       (op1_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            held_ra0    <= ZERO_REG;
            held_ra1    <= ZERO_REG;
            op0_q       <= '0;
            op1_q       <= '0;
            out_valid_q <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            op0_q <= op0_d;
            op1_q <= op1_d;

            if (accept) begin
                held_ra0 <= bus.req_ra0;
                held_ra1 <= bus.req_ra1;
            end

            unique case (state)
                IDLE: begin
                    out_valid_q <= 1'b0;
                    if (accept)
                        state <= RDWAIT;
                end
                RDWAIT: begin
                    state       <= HOLD;
                    out_valid_q <= 1'b1;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= accept ? RDWAIT : IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase

            if (bus.req_valid && !ready && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    a_no_accept_on_write: assert property (@(posedge clk) disable iff (!rst_n)
        bus.req_ready |-> !bus.wb_we);

    a_valid_only_in_hold: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid_q == (state == HOLD));

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Bench for regfile_operand_fetch: BRAM register file model, architectural reference model,
// directed scenarios with literal expectations and a randomized phase.
module tb_regfile_operand_fetch;
    import regfile_operand_fetch_pkg::*;

    localparam int W  = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CW-1:0] stall_cnt;

    regfile_operand_fetch_if #(.WIDTH(W)) bus ();

    regfile_operand_fetch #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_val(input int i);
        return 32'h9E3779B9 * (i + 1);
    endfunction

    // Register file environment: read-first synchronous BRAM, contents seeded under reset.
    logic [31:0] mem [32];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
        end else if (bus.rf_we) begin
            mem[bus.rf_wa] <= bus.rf_wd;
        end
        bus.rf_rd0 <= mem[bus.rf_ra0];
        bus.rf_rd1 <= mem[bus.rf_ra1];
    end

    // Architectural reference: one request in flight, operands equal register contents.
    logic [31:0]   arch [32];
    logic          pend;
    int unsigned   age;
    logic [4:0]    pra0, pra1;
    logic [CW-1:0] stall_m;
    logic          exp_valid, exp_ready, exp_acc;

    always @(negedge clk) begin
        if (!rst_n) begin
            pend    = 1'b0;
            age     = 0;
            stall_m = '0;
            for (int i = 0; i < 32; i++) arch[i] = (i == 0) ? 32'h0 : init_val(i);
        end else begin
            exp_valid = pend && (age >= 2);
            exp_ready = !bus.wb_we && (!pend || (exp_valid && bus.out_ready));
            exp_acc   = bus.req_valid && exp_ready;

            chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
            chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
            chk("stall_cnt", 32'(stall_cnt), 32'(stall_m));
            chk("rf_we", 32'(bus.rf_we), 32'(bus.wb_we));
            chk("rf_wa", 32'(bus.rf_wa), 32'(bus.wb_wa));
            chk("rf_wd", bus.rf_wd, bus.wb_wd);
            if (exp_acc) begin
                chk("rf_ra0", 32'(bus.rf_ra0), 32'(bus.req_ra0));
                chk("rf_ra1", 32'(bus.rf_ra1), 32'(bus.req_ra1));
            end
            if (exp_valid) begin
                chk("op0", bus.op0, arch[pra0]);
                chk("op1", bus.op1, arch[pra1]);
            end

            if (bus.req_valid && !exp_ready && (stall_m != '1)) stall_m = stall_m + 1'b1;
            if (exp_valid && bus.out_ready) pend = 1'b0;
            if (pend) age++;
            if (exp_acc) begin
                pend = 1'b1;
                age  = 1;
                pra0 = bus.req_ra0;
                pra1 = bus.req_ra1;
            end
            if (bus.wb_we && (bus.wb_wa != 5'd0)) arch[bus.wb_wa] = bus.wb_wd;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [4:0] a0, input logic [4:0] a1);
        bus.req_valid = v;
        bus.req_ra0   = a0;
        bus.req_ra1   = a1;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] wa, input logic [31:0] wd);
        bus.wb_we = we;
        bus.wb_wa = wa;
        bus.wb_wd = wd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        set_req(1'b0, 5'd0, 5'd0);
        set_wb(1'b0, 5'd0, 32'h0);
        bus.out_ready = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("reset out_valid", 32'(bus.out_valid), 32'h0);
        chk("reset op0", bus.op0, 32'h0);
        chk("reset op1", bus.op1, 32'h0);
        chk("reset stall_cnt", 32'(stall_cnt), 32'h0);
        chk("reset req_ready", 32'(bus.req_ready), 32'h1);
        step();
        rst_n = 1'b1;

        // Preload x5, x6 and a write to x0 that must never be observed.
        set_wb(1'b1, 5'd5, 32'h1234);         step();
        set_wb(1'b1, 5'd6, 32'hABCD);         step();
        set_wb(1'b1, 5'd0, 32'hFFFF);         step();

        // Basic read, 2-cycle latency.
        set_wb(1'b0, 5'd0, 32'h0);
        set_req(1'b1, 5'd5, 5'd6);
        bus.out_ready = 1'b1;                 step();
        set_req(1'b0, 5'd0, 5'd0);            step();
        set_req(1'b1, 5'd0, 5'd0);
        @(negedge clk);
        chk("basic out_valid", 32'(bus.out_valid), 32'h1);
        chk("basic op0", bus.op0, 32'h1234);
        chk("basic op1", bus.op1, 32'hABCD);
        step();

        // x0 reads as zero.
        set_req(1'b0, 5'd0, 5'd0);            step();
        @(negedge clk);
        chk("x0 out_valid", 32'(bus.out_valid), 32'h1);
        chk("x0 op0", bus.op0, 32'h0);
        chk("x0 op1", bus.op1, 32'h0);
        step();

        // Write steals the port; request accepted on the next write-free cycle.
        set_req(1'b1, 5'd7, 5'd1);
        set_wb(1'b1, 5'd7, 32'h77);
        @(negedge clk);
        chk("steal req_ready", 32'(bus.req_ready), 32'h0);
        step();
        set_wb(1'b0, 5'd0, 32'h0);
        @(negedge clk);
        chk("steal accept", 32'(bus.req_ready), 32'h1);
        chk("steal stall_cnt", 32'(stall_cnt), 32'h1);
        step();
        set_req(1'b0, 5'd0, 5'd0);            step();
        set_req(1'b1, 5'd9, 5'd9);
        @(negedge clk);
        chk("steal op0", bus.op0, 32'h77);
        step();

        // Forward during RDWAIT, both sources equal.
        set_req(1'b0, 5'd0, 5'd0);
        set_wb(1'b1, 5'd9, 32'hDEAD);         step();
        set_wb(1'b0, 5'd0, 32'h0);
        set_req(1'b1, 5'd2, 5'd3);
        @(negedge clk);
        chk("rdwait fwd op0", bus.op0, 32'hDEAD);
        chk("rdwait fwd op1", bus.op1, 32'hDEAD);
        step();

        // Forward during HOLD under backpressure; handshake-cycle write not applied.
        set_req(1'b0, 5'd0, 5'd0);            step();
        bus.out_ready = 1'b0;
        set_wb(1'b1, 5'd3, 32'h55);
        @(negedge clk);
        chk("hold out_valid", 32'(bus.out_valid), 32'h1);
        step();
        bus.out_ready = 1'b1;
        set_wb(1'b1, 5'd3, 32'h66);
        @(negedge clk);
        chk("hold fwd op1", bus.op1, 32'h55);
        step();
        set_wb(1'b0, 5'd0, 32'h0);
        set_req(1'b1, 5'd5, 5'd6);
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("departed out_valid", 32'(bus.out_valid), 32'h0);
        step();

        // Reset while holding operands.
        set_req(1'b0, 5'd0, 5'd0);            step();
        @(negedge clk);
        chk("pre-reset out_valid", 32'(bus.out_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset out_valid", 32'(bus.out_valid), 32'h0);
        chk("async reset op0", bus.op0, 32'h0);
        chk("async reset op1", bus.op1, 32'h0);
        chk("async reset stall_cnt", 32'(stall_cnt), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset req_ready", 32'(bus.req_ready), 32'h1);
        chk("post-reset out_valid", 32'(bus.out_valid), 32'h0);
        step();

        // Randomized traffic over a small register window to provoke forwarding.
        for (int n = 0; n < 2000; n++) begin
            set_req(($urandom % 4) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            set_wb(($urandom % 3) == 0, 5'($urandom_range(0, 7)), $urandom);
            bus.out_ready = ($urandom % 3) != 0;
            step();
        end

        // Stall counter saturation.
        bus.out_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            set_req(1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            set_wb(1'b1, 5'($urandom_range(0, 31)), $urandom);
            step();
        end
        @(negedge clk);
        chk("stall saturate", 32'(stall_cnt), 32'hFF);
        step();
        set_req(1'b0, 5'd0, 5'd0);
        set_wb(1'b0, 5'd0, 32'h0);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_operand_fetch.md
Name: regfile_operand_fetch

Overview:
- Operand-fetch stage that sits directly in front of the BRAM-based register file and consumes its read data.
- Turns the file's 1-cycle synchronous read into a valid/ready operand stream for execute.
- The file's single port per bank is stolen by writes, so this stage holds off reads during a write cycle.
- The file has no r/w forwarding, so this stage forwards writeback data into in-flight and held operands and forces x0 to zero.

Parameters:
- WIDTH, 32, data width of registers and operands.
- CNT_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  decode presents a read request.
- req_ready  out  1  stage accepts the request this cycle.
- req_ra0  in  5  source register 0 address.
- req_ra1  in  5  source register 1 address.
- wb_we  in  1  writeback write enable.
- wb_wa  in  5  writeback address.
- wb_wd  in  WIDTH  writeback data.
- rf_ra0  out  5  register file read address 0.
- rf_ra1  out  5  register file read address 1.
- rf_we  out  1  register file write enable (= wb_we).
- rf_wa  out  5  register file write address (= wb_wa).
- rf_wd  out  WIDTH  register file write data (= wb_wd).
- rf_rd0  in  WIDTH  register file read data 0, valid 1 cycle after address.
- rf_rd1  in  WIDTH  register file read data 1, valid 1 cycle after address.
- out_valid  out  1  operands valid to execute.
- out_ready  in  1  execute consumes operands.
- op0  out  WIDTH  operand 0 (registered).
- op1  out  WIDTH  operand 1 (registered).
- stall_cnt  out  CNT_W  count of cycles with req_valid & !req_ready.

Behaviour:
- Reset (async, rst_n=0): state IDLE; out_valid=0; op0=op1=0; held addresses 0; stall_cnt=0.
- Write path: rf_we/rf_wa/rf_wd are combinational pass-through of wb_*. A write has absolute priority over reads.
- rf_ra0/1 = req_ra0/1 in the cycle a request is accepted; otherwise the held addresses.
- req_ready = !wb_we && (state==IDLE || (state==HOLD && out_ready)).
- Acceptance: req_valid & req_ready latches ra0/ra1 into held registers and moves to RDWAIT.
- IDLE: out_valid=0. On accept go to RDWAIT; else stay.
- RDWAIT: rf_rd0/1 are valid this cycle.
  - Capture opN = 0 if held raN==0.
  - Else wb_wd if wb_we && wb_wa==raN.
  - Else rf_rdN.
  - Next state HOLD; req_ready=0.
- HOLD: out_valid=1; op0/op1 stable unless forwarded.
  - If wb_we && wb_wa==raN && raN!=0 && !out_ready, opN <= wb_wd.
  - On out_ready: operands depart with their current register values. A write in the handshake cycle is not applied to the departing operands.
  - Then: accept → RDWAIT; else IDLE.
- Throughput: 1 operand pair per 2 cycles max. Latency: request accept to out_valid = 2 cycles.
- Both sources equal: each is resolved independently and identically.
- wb_wa==0 writes are passed to the file, but never forwarded.
- stall_cnt increments on req_valid & !req_ready and saturates at all-ones.
- Reset mid-RDWAIT/HOLD: pending operands are dropped, with no output pulse.

Decomposition:
- Shared package:
  - state encoding localparams (IDLE=2'd0, RDWAIT=2'd1, HOLD=2'd2);
  - REG_ADDR_W=5 and ZERO_REG=5'd0 constants.
- One natural sub-module: operand_select. It is a combinational mux for one operand (zero / forward / rf / hold) and is instantiated twice.

Test Plan:
- Basic read: preload x5=0x1234, x6=0xABCD. Request ra0=5, ra1=6 at cycle t, with out_ready=1. Required: out_valid at t+2 with op0=0x1234, op1=0xABCD.
- x0: request ra0=0, ra1=0 after writing x0=0xFFFF. Required: op0=op1=0.
- Write-steal: req_valid with wb_we=1 (wa=7). Required: req_ready=0, stall_cnt +1, and the request is accepted the next write-free cycle.
- RDWAIT forward: accept ra0=9; next cycle wb_we, wa=9, wd=0xDEAD. Required: op0=0xDEAD, not the stale RAM value.
- HOLD forward and backpressure:
  - Hold out_ready=0 with ra1=3, then write x3=0x55 → op1 becomes 0x55.
  - A write x3=0x66 in the out_ready cycle → the departing op1 is 0x55.
- Reset mid-HOLD: drop rst_n while out_valid=1. Required: out_valid=0 and op0/op1/stall_cnt=0 immediately; after release, IDLE with req_ready=1.
